// File: rtl/mont_mul_cios.sv
// mont_mul_cios: word-serial Montgomery multiplier (CIOS ordering).
//
// Computes result = a * b * R^-1 mod n, where R = 2^(32*NWORDS). One 32-bit word of a is
// consumed every two clocks. The first clock is a multiply-accumulate of that word against b.
// The second clock adds the reduction multiple m*n and shifts T right by one word.
//
// Latency: with start high in cycle k, done pulses in cycle k + 2*NWORDS + 2.
//
// Ports:
//   clk      in   system clock, all logic on the rising edge
//   rst      in   synchronous, active-high reset
//   start    in   single-cycle request, sampled only while idle
//   a, b     in   WIDTH-bit operands, each expected to be < n
//   n        in   WIDTH-bit odd modulus
//   n0prime  in   -n^-1 mod 2^32
//   result   out  Montgomery product (< n), held until the next completion or reset
//   busy     out  high from the cycle after acceptance until done
//   done     out  one-cycle completion pulse
//   err      out  n0prime consistency failure, valid with done
//
// Optional feature (macro MONT_N0_CHECK_EN): at acceptance, check that
// n[31:0] * n0prime == 32'hFFFFFFFF (mod 2^32). On a mismatch the operation still runs at the
// normal latency, and then it completes with result = 0 and err = 1. If the macro is not
// defined, err is tied to 0.

module mont_mul_cios #(
    parameter int unsigned  NWORDS = 32,
    localparam int unsigned WIDTH  = 32 * NWORDS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] n,
    input  logic [31:0]      n0prime,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done,
    output logic             err
);

    // T carries 33 guard bits so the accumulate step cannot overflow while a, b < n.
    localparam int unsigned TW = WIDTH + 33;
    localparam int unsigned IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IW-1:0] LastIdx = IW'(NWORDS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StMac,
        StRed,
        StFinal
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;       // shifts right one word per RED, so a_q[31:0] is a_i
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [31:0]      n0p_q, n0p_d;
    logic [TW-1:0]    t_q, t_d;
    logic [IW-1:0]    i_q, i_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    // Datapath terms
    logic [WIDTH+31:0] mac_prod;
    logic [TW-1:0]     mac_sum;
    logic [31:0]       m;
    logic [WIDTH+31:0] red_prod;
    logic [TW:0]       red_sum;
    logic              t_ge_n;
    logic [TW-1:0]     t_minus_n;
    logic              unused_bits;

    assign mac_prod = {{WIDTH{1'b0}}, a_q[31:0]} * {32'b0, b_q};
    assign mac_sum  = t_q + {1'b0, mac_prod};

    // m makes the low word of T + m*n zero, so the shift below drops no information.
    assign m        = t_q[31:0] * n0p_q;
    assign red_prod = {{WIDTH{1'b0}}, m} * {32'b0, n_q};
    assign red_sum  = {1'b0, t_q} + {2'b0, red_prod};

    assign t_ge_n    = (t_q >= {33'b0, n_q});
    assign t_minus_n = t_q - {33'b0, n_q};

    // The low word of red_sum is zero by construction. The upper bits of the difference are
    // only meaningful when t_ge_n is low, and in that case the difference is not selected.
    assign unused_bits = ^{red_sum[31:0], t_minus_n[TW-1:WIDTH]};

`ifdef MONT_N0_CHECK_EN
    logic        n0_bad_q, n0_bad_d;
    logic [31:0] n0_check;

    assign n0_check = n[31:0] * n0prime;
`endif

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        n_d      = n_q;
        n0p_d    = n0p_q;
        t_d      = t_q;
        i_d      = i_q;
        result_d = result_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = err_q;
`ifdef MONT_N0_CHECK_EN
        n0_bad_d = n0_bad_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    n_d     = n;
                    n0p_d   = n0prime;
                    t_d     = '0;
                    i_d     = '0;
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                    state_d = StMac;
`ifdef MONT_N0_CHECK_EN
                    n0_bad_d = (n0_check != 32'hFFFF_FFFF);
`endif
                end
            end

            StMac: begin
                t_d     = mac_sum;
                state_d = StRed;
            end

            StRed: begin
                t_d = {31'b0, red_sum[TW:32]};
                a_d = a_q >> 32;
                i_d = i_q + IW'(1);
                if (i_q == LastIdx) begin
                    state_d = StFinal;
                end else begin
                    state_d = StMac;
                end
            end

            StFinal: begin
                result_d = t_ge_n ? t_minus_n[WIDTH-1:0] : t_q[WIDTH-1:0];
`ifdef MONT_N0_CHECK_EN
                if (n0_bad_q) begin
                    result_d = '0;
                    err_d    = 1'b1;
                end
`endif
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            n_q      <= '0;
            n0p_q    <= '0;
            t_q      <= '0;
            i_q      <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            n_q      <= n_d;
            n0p_q    <= n0p_d;
            t_q      <= t_d;
            i_q      <= i_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

`ifdef MONT_N0_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            n0_bad_q <= 1'b0;
        end else begin
            n0_bad_q <= n0_bad_d;
        end
    end
`endif

    assign result = result_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;

endmodule

// File: tb/tb_mont_mul_cios.sv
module tb_mont_mul_cios;

    localparam logic [63:0] NMOD = 64'hFFFF_FFFF_FFFF_FFC5;  // R mod n = 59
    localparam logic [63:0] XVAL = 64'h1234_5678_9ABC_DEF0;

    logic        clk;
    logic        rst;
    logic        start;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] n;
    logic [31:0] n0prime;
    logic [63:0] result;
    logic        busy;
    logic        done;
    logic        err;

    int total;
    int bad;

    mont_mul_cios #(
        .NWORDS(2)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .n      (n),
        .n0prime(n0prime),
        .result (result),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // -n^-1 mod 2^32 by Newton iteration on the odd low word.
    function automatic logic [31:0] calc_n0prime(input logic [31:0] n0);
        logic [31:0] x;
        x = n0;
        for (int k = 0; k < 5; k++) begin
            x = x * (32'd2 - n0 * x);
        end
        return -x;
    endfunction

    // Drive a request for one cycle; returns at the falling edge of cycle 1 after acceptance.
    task automatic start_op(input logic [63:0] ia, input logic [63:0] ib, input logic [63:0] in,
                            input logic [31:0] in0);
        @(negedge clk);
        a       = ia;
        b       = ib;
        n       = in;
        n0prime = in0;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Sample each falling edge starting at cycle c0 (current edge) until done.
    // berr counts cycles where busy was wrong (high before done, low at done).
    task automatic wait_done(input int c0, output int lat, output int berr);
        lat  = -1;
        berr = 0;
        for (int c = c0; c <= c0 + 40; c++) begin
            if (c > c0) @(negedge clk);
            if (done === 1'b1) begin
                lat = c;
                if (busy !== 1'b0) berr++;
                break;
            end
            if (busy !== 1'b1) berr++;
        end
    endtask

    task automatic count_done(input int cycles, output int cnt);
        cnt = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (done === 1'b1) cnt++;
        end
    endtask

    initial begin
        int          lat;
        int          berr;
        int          cnt;
        logic [31:0] np;
        logic [63:0] rn;
        logic [63:0] ra;
        logic [63:0] rb;
        logic [63:0] res;

        total   = 0;
        bad     = 0;
        rst     = 1'b1;
        start   = 1'b0;
        a       = '0;
        b       = '0;
        n       = '0;
        n0prime = '0;
        np      = calc_n0prime(NMOD[31:0]);

        repeat (3) @(negedge clk);
        check("reset_result", result, 64'd0);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_err", err, 1'b0);
        rst = 1'b0;

        // R * R * R^-1 = R mod n = 59
        start_op(64'd59, 64'd59, NMOD, np);
        wait_done(1, lat, berr);
        check("r_r_latency", lat, 6);
        check("r_r_busy", berr, 0);
        check("r_r_result", result, 64'd59);
        check("r_r_err", err, 1'b0);

        // x * R * R^-1 = x
        start_op(XVAL, 64'd59, NMOD, np);
        wait_done(1, lat, berr);
        check("x_r_latency", lat, 6);
        check("x_r_result", result, XVAL);

        start_op(64'd0, NMOD - 64'd1, NMOD, np);
        wait_done(1, lat, berr);
        check("zero_result", result, 64'd0);

        // Start in the done-pulse cycle is accepted.
        a       = 64'd59;
        b       = 64'd59;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(1, lat, berr);
        check("start_on_done_latency", lat, 6);
        check("start_on_done_result", result, 64'd59);

        // A second start while busy is ignored.
        start_op(XVAL, 64'd59, NMOD, np);
        @(negedge clk);
        @(negedge clk);
        a     = 64'd7;
        b     = 64'd9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(4, lat, berr);
        check("busy_start_latency", lat, 6);
        check("busy_start_busy", berr, 0);
        check("busy_start_result", result, XVAL);
        count_done(12, cnt);
        check("busy_start_no_second_done", cnt, 0);
        check("busy_start_idle", busy, 1'b0);

        // Reset during cycle 3 aborts the operation.
        start_op(64'd59, 64'd59, NMOD, np);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_result", result, 64'd0);
        count_done(12, cnt);
        check("abort_no_done", cnt, 0);
        start_op(XVAL, 64'd59, NMOD, np);
        wait_done(1, lat, berr);
        check("after_abort_latency", lat, 6);
        check("after_abort_result", result, XVAL);

        // Wrong n0prime.
        start_op(XVAL, 64'd59, NMOD, 32'h0000_0001);
        wait_done(1, lat, berr);
        check("bad_n0_latency", lat, 6);
`ifdef MONT_N0_CHECK_EN
        check("bad_n0_err", err, 1'b1);
        check("bad_n0_result", result, 64'd0);
`else
        check("bad_n0_err", err, 1'b0);
`endif
        start_op(64'd59, 64'd59, NMOD, np);
        check("err_clears_on_start", err, 1'b0);
        wait_done(1, lat, berr);
        check("good_after_bad_result", result, 64'd59);

        // Random operands against a wide-arithmetic reference: result * R == a * b (mod n).
        for (int t = 0; t < 10; t++) begin
            rn = {$urandom(), $urandom()} | 64'h0000_0001_0000_0001;
            ra = {$urandom(), $urandom()} % rn;
            rb = {$urandom(), $urandom()} % rn;
            start_op(ra, rb, rn, calc_n0prime(rn[31:0]));
            wait_done(1, lat, berr);
            res = result;
            check("rand_latency", lat, 6);
            check("rand_lt_n", (res < rn), 1'b1);
            check("rand_mont", ({res, 64'b0} % {64'b0, rn}),
                  (({64'b0, ra} * {64'b0, rb}) % {64'b0, rn}));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
